// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the MIPS fetch stage:
//               the HALT opcode, the NOP word, the PC increment and the
//               fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Opcode field value ([31:26]) that stops instruction fetch
    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    // All-zero word; injected into IF/ID as a bubble
    localparam int NOP_WORD = 0;

    // Byte distance between consecutive instruction words
    localparam int PC_INCR = 4;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Bundle of every non-clock/reset signal of the fetch stage.
//               slave  - seen by the fetch stage (controls in, IF/ID out)
//               master - seen by the driver (decode, debug unit or bench)
//               Controls : enable, stall_flag, flag_jump, flag_jump_register,
//                          flag_branch and their target addresses
//               Program  : imem_wr_en / imem_wr_addr / imem_wr_data
//               Outputs  : out_pc_branch, out_instruccion, out_pc, halted
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if #(
    parameter int len     = 32,
    parameter int NB_ADDR = 10
);
    logic               enable;
    logic               stall_flag;
    logic               flag_jump;
    logic               flag_jump_register;
    logic [len-1:0]     in_pc_jump;
    logic [len-1:0]     in_pc_register;
    logic               flag_branch;
    logic [len-1:0]     in_pc_branch_target;
    logic               imem_wr_en;
    logic [NB_ADDR-1:0] imem_wr_addr;
    logic [len-1:0]     imem_wr_data;
    logic [len-1:0]     out_pc_branch;
    logic [len-1:0]     out_instruccion;
    logic [len-1:0]     out_pc;
    logic               halted;

    modport slave (
        input  enable, stall_flag, flag_jump, flag_jump_register,
               in_pc_jump, in_pc_register, flag_branch, in_pc_branch_target,
               imem_wr_en, imem_wr_addr, imem_wr_data,
        output out_pc_branch, out_instruccion, out_pc, halted
    );

    modport master (
        output enable, stall_flag, flag_jump, flag_jump_register,
               in_pc_jump, in_pc_register, flag_branch, in_pc_branch_target,
               imem_wr_en, imem_wr_addr, imem_wr_data,
        input  out_pc_branch, out_instruccion, out_pc, halted
    );
endinterface
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory
// Description : Word-addressed instruction store, 2^NB_ADDR words of len bits.
//               Asynchronous read; synchronous write. A read of the index
//               being written in the same cycle returns the old word.
//   clk     in  clock
//   wr_en   in  write strobe
//   wr_addr in  write word index
//   wr_data in  write word
//   rd_addr in  read word index
//   rd_data out read word (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter int len     = 32,
    parameter int NB_ADDR = 10
) (
    input  wire logic               clk,
    input  wire logic               wr_en,
    input  wire logic [NB_ADDR-1:0] wr_addr,
    input  wire logic [len-1:0]     wr_data,
    input  wire logic [NB_ADDR-1:0] rd_addr,
    output logic      [len-1:0]     rd_data
);
    localparam int DEPTH = 1 << NB_ADDR;

    // Contents are deliberately not reset so a loaded program survives reset
    logic [len-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : IF stage of the 5-stage MIPS core. Holds the PC and the
//               instruction memory and drives the IF/ID register.
//   clk    in  clock, all state on posedge
//   reset  in  synchronous active-low reset (memory contents kept)
//   bus    slave modport of instruction_fetch_if:
//          enable gates every register except the memory write port;
//          stall_flag holds PC and IF/ID; flag_branch / flag_jump_register /
//          flag_jump redirect the PC (in that priority) and flush IF/ID;
//          imem_wr_* load the program; out_pc_branch / out_instruccion form
//          IF/ID; out_pc is the current PC; halted flags a retired HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int         len         = 32,
    parameter int         NB_ADDR     = 10,
    parameter logic [5:0] HALT_OPCODE = mips_pkg::HALT_OPCODE
) (
    input  wire logic          clk,
    input  wire logic          reset,
    instruction_fetch_if.slave bus
);
    logic [len-1:0] pc_q,     pc_d;
    logic [len-1:0] pc_br_q,  pc_br_d;
    logic [len-1:0] instr_q,  instr_d;
    logic           halted_q, halted_d;
    fetch_state_t   state_q,  state_d;

    logic [len-1:0] fetch_word;
    logic [len-1:0] pc_plus4;
    logic [len-1:0] redirect_target;
    logic           redirect;

    // Only the word-index bits of the PC address the memory; the byte
    // offset and any bits above the memory size are intentionally ignored.
    logic pc_unused_bits;
    assign pc_unused_bits = ^{pc_q[len-1:NB_ADDR+2], pc_q[1:0]};

    instruction_memory #(
        .len     (len),
        .NB_ADDR (NB_ADDR)
    ) u_imem (
        .clk     (clk),
        .wr_en   (bus.imem_wr_en),
        .wr_addr (bus.imem_wr_addr),
        .wr_data (bus.imem_wr_data),
        .rd_addr (pc_q[NB_ADDR+1:2]),
        .rd_data (fetch_word)
    );

    assign pc_plus4 = pc_q + len'(PC_INCR);
    assign redirect = bus.flag_branch | bus.flag_jump_register | bus.flag_jump;

    // A resolved branch is older than the jump sitting in decode, so it wins
    always_comb begin
        if (bus.flag_branch) begin
            redirect_target = bus.in_pc_branch_target;
        end else if (bus.flag_jump_register) begin
            redirect_target = bus.in_pc_register;
        end else begin
            redirect_target = bus.in_pc_jump;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        pc_br_d = pc_br_q;
        instr_d = instr_q;
        state_d = state_q;

        if (!bus.enable || state_q == HALTED) begin
            // frozen: debug gate closed, or the core has halted for good
        end else if (redirect) begin
            // Flush wins over stall and cancels a HALT waiting in IF/ID
            pc_d    = redirect_target;
            pc_br_d = len'(NOP_WORD);
            instr_d = len'(NOP_WORD);
            state_d = FETCH;
        end else if (!bus.stall_flag) begin
            case (state_q)
                FETCH: begin
                    pc_br_d = pc_plus4;
                    instr_d = fetch_word;
                    if (fetch_word[31:26] == HALT_OPCODE) begin
                        state_d = HALT_PEND;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
                HALT_PEND: begin
                    // HALT leaves IF/ID; a bubble replaces it and fetch stops
                    pc_br_d = pc_plus4;
                    instr_d = len'(NOP_WORD);
                    state_d = HALTED;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= '0;
            pc_br_q  <= '0;
            instr_q  <= '0;
            halted_q <= 1'b0;
            state_q  <= FETCH;
        end else begin
            pc_q     <= pc_d;
            pc_br_q  <= pc_br_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
            state_q  <= state_d;
        end
    end

    assign bus.out_pc          = pc_q;
    assign bus.out_pc_branch   = pc_br_q;
    assign bus.out_instruccion = instr_q;
    assign bus.halted          = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. Each stimulus
//               cycle advances a behavioural model and queues the outputs
//               expected after the next clock edge; a monitor pops and
//               compares them independently of the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
    localparam int LEN   = 32;
    localparam int NBA   = 10;
    localparam int DEPTH = 1 << NBA;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_if #(.len(LEN), .NB_ADDR(NBA)) bus ();

    instruction_fetch #(
        .len         (LEN),
        .NB_ADDR     (NBA),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pcb;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        h;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model: architectural view of the stage
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_pcb, m_ins;
    bit          m_halted;    // HALT has retired, machine frozen until reset
    bit          m_hold_halt; // HALT word currently sitting in IF/ID

    task automatic model_step();
        logic [31:0] w;
        exp_t        e;
        w = m_mem[(m_pc / 4) % DEPTH];
        if (!reset) begin
            m_pc = 0; m_pcb = 0; m_ins = 0;
            m_halted = 0; m_hold_halt = 0;
        end else if (bus.enable && !m_halted) begin
            if (bus.flag_branch || bus.flag_jump_register || bus.flag_jump) begin
                if (bus.flag_branch)             m_pc = bus.in_pc_branch_target;
                else if (bus.flag_jump_register) m_pc = bus.in_pc_register;
                else                             m_pc = bus.in_pc_jump;
                m_pcb = 0; m_ins = 0; m_hold_halt = 0;
            end else if (!bus.stall_flag) begin
                m_pcb = m_pc + 4;
                if (m_hold_halt) begin
                    m_ins = 0; m_hold_halt = 0; m_halted = 1;
                end else begin
                    m_ins = w;
                    if (w[31:26] == 6'b111111) m_hold_halt = 1;
                    else                       m_pc = m_pc + 4;
                end
            end
        end
        if (bus.imem_wr_en) m_mem[bus.imem_wr_addr] = bus.imem_wr_data;
        e.pcb = m_pcb; e.ins = m_ins; e.pc = m_pc; e.h = m_halted;
        sbq.push_back(e);
    endtask

    // Inputs for this cycle are already set; record expectation, wait a cycle
    task automatic cyc();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.enable              = 1'b1;
        bus.stall_flag          = 1'b0;
        bus.flag_jump           = 1'b0;
        bus.flag_jump_register  = 1'b0;
        bus.flag_branch         = 1'b0;
        bus.in_pc_jump          = '0;
        bus.in_pc_register      = '0;
        bus.in_pc_branch_target = '0;
        bus.imem_wr_en          = 1'b0;
    endtask

    task automatic write_word(input int idx, input logic [31:0] data);
        bus.imem_wr_en   = 1'b1;
        bus.imem_wr_addr = NBA'(idx);
        bus.imem_wr_data = data;
    endtask

    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'b111111) w[31] = 1'b0;
        return w;
    endfunction

    // Monitor: compare the DUT after every edge that has an expectation queued
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                vectors++;
                if (bus.out_pc_branch !== e.pcb || bus.out_instruccion !== e.ins ||
                    bus.out_pc !== e.pc || bus.halted !== e.h) begin
                    miscompares++;
                    $display("FAIL ifid_check t=%0t: got pcb=%h ins=%h pc=%h halted=%b, expected pcb=%h ins=%h pc=%h halted=%b",
                             $time, bus.out_pc_branch, bus.out_instruccion, bus.out_pc,
                             bus.halted, e.pcb, e.ins, e.pc, e.h);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'h2001_0001;
        prog[1] = 32'h2002_0002;
        prog[2] = 32'h2003_0003;
        prog[3] = 32'h2004_0004;

        reset = 1'b0;
        idle();
        bus.imem_wr_addr = '0;
        bus.imem_wr_data = '0;
        m_pc = 0; m_pcb = 0; m_ins = 0; m_halted = 0; m_hold_halt = 0;
        @(negedge clk);

        // Program load under reset; every cycle also checks the reset state
        for (int i = 0; i < DEPTH; i++) begin
            write_word(i, (i < 4) ? prog[i] : plain_word());
            cyc();
        end

        // Straight-line fetch with a two-cycle stall while B is in IF/ID
        idle(); reset = 1'b1;
        cyc(); cyc();
        bus.stall_flag = 1'b1; cyc(); cyc();
        idle(); cyc(); cyc();

        // Jump together with stall: redirect wins
        bus.flag_jump = 1'b1; bus.in_pc_jump = 32'h40; bus.stall_flag = 1'b1; cyc();
        idle(); cyc(); cyc();

        // Branch and jump in the same cycle: branch target taken
        bus.flag_branch = 1'b1; bus.in_pc_branch_target = 32'h80;
        bus.flag_jump   = 1'b1; bus.in_pc_jump          = 32'h40; cyc();
        idle(); cyc(); cyc();

        // HALT at mem[2]: PC freezes at 8, later jump ignored
        reset = 1'b0; write_word(2, HALT_WORD); cyc();
        idle(); reset = 1'b1;
        repeat (5) cyc();
        bus.flag_jump = 1'b1; bus.in_pc_jump = 32'h40; cyc();
        idle(); cyc(); cyc();

        // Branch while HALT is pending: HALT cancelled, fetch resumes at 0x20
        reset = 1'b0; write_word(2, prog[2]); cyc();
        write_word(5, HALT_WORD); cyc();
        idle(); reset = 1'b1;
        repeat (6) cyc();
        bus.flag_branch = 1'b1; bus.in_pc_branch_target = 32'h20; cyc();
        idle(); repeat (3) cyc();

        // Debug gate closed for three cycles, with a redirect offered
        bus.enable = 1'b0; bus.flag_jump = 1'b1; bus.in_pc_jump = 32'h100;
        repeat (3) cyc();
        idle(); cyc(); cyc();

        // Reset mid-run: memory keeps the program
        reset = 1'b0; cyc();
        reset = 1'b1; repeat (4) cyc();

        // Randomised phase
        for (int n = 0; n < 3000; n++) begin
            reset                   = ($urandom_range(0, 149) != 0);
            bus.enable              = ($urandom_range(0, 19) != 0);
            bus.stall_flag          = ($urandom_range(0, 7) == 0);
            bus.flag_branch         = ($urandom_range(0, 19) == 0);
            bus.flag_jump_register  = ($urandom_range(0, 19) == 0);
            bus.flag_jump           = ($urandom_range(0, 19) == 0);
            bus.in_pc_branch_target = 32'($urandom_range(0, 127)) * 4;
            bus.in_pc_register      = ($urandom_range(0, 15) == 0) ? $urandom
                                                                   : 32'($urandom_range(0, 127)) * 4;
            bus.in_pc_jump          = 32'($urandom_range(0, 127)) * 4;
            bus.imem_wr_en          = ($urandom_range(0, 5) == 0);
            bus.imem_wr_addr        = NBA'($urandom_range(0, 127));
            bus.imem_wr_data        = ($urandom_range(0, 7) == 0) ? (HALT_WORD | 32'($urandom_range(0, 255)))
                                                                  : plain_word();
            cyc();
        end

        idle(); reset = 1'b1;
        @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
